bus_arbiter2x12: RTL and testbench

BUS_ARBITER2X12 -- requirements
Module: bus_arbiter2x12

---
 rtl/bus_arbiter2x12.sv | 94 +++++++++
 tb/tb_bus_arbiter2x12.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2x12.sv
// Two-requester bus arbiter: last-granted tie-break, hold limit under contention,
// registered grant/select/enable, and a combinational shared-bus mux.
module bus_arbiter2x12 #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              enable,
    output logic [DATA_W-1:0] bus_out
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last;
    logic               last_nxt;
    logic               sel_nxt;

    // State and registered outputs; outputs decode the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            sel    <= 1'b0;
            enable <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last   <= last_nxt;
            gnt0   <= (state_nxt == OWN0);
            gnt1   <= (state_nxt == OWN1);
            sel    <= sel_nxt;
            enable <= (state_nxt != IDLE);
        end
    end

    // Next-state, hold counter and tie-break bookkeeping
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        sel_nxt   = sel;

        case (state)
            IDLE: begin
                if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
                else if (req0)     state_nxt = OWN0;
                else if (req1)     state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)                      state_nxt = req1 ? OWN1 : IDLE;
                else if (req1 && cnt == CNT_MAX) state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)                      state_nxt = req0 ? OWN0 : IDLE;
                else if (req0 && cnt == CNT_MAX) state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase

        // Any entry into an owner state restarts the hold count; sel holds through IDLE
        if (state_nxt != state && state_nxt != IDLE) begin
            cnt_nxt  = '0;
            last_nxt = (state_nxt == OWN1);
            sel_nxt  = (state_nxt == OWN1);
        end else if (state_nxt == state && state != IDLE && cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    assign bus_out = enable ? (sel ? data1 : data0) : '0;

endmodule

// File: tb/tb_bus_arbiter2x12.sv
// Randomized and directed bench for bus_arbiter2x12 against an ownership-run reference model.
module tb_bus_arbiter2x12;

    localparam int unsigned DW = 12;
    localparam int unsigned MH = 4;

    logic          clk;
    logic          rst_n;
    logic          req0;
    logic          req1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          gnt0;
    logic          gnt1;
    logic          sel;
    logic          enable;
    logic [DW-1:0] bus_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus (-1 none), how many cycles in a row, who got it last
    int   m_owner;
    int   m_hold;
    int   m_last;
    logic m_sel;

    bus_arbiter2x12 #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .enable  (enable),
        .bus_out (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 1;
        m_sel   = 1'b0;
    endtask

    task automatic m_step(input logic r0, input logic r1);
        int  nxt;
        bit  mine;
        bit  other;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
        end else begin
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (!mine)                         nxt = other ? 1 - m_owner : -1;
            else if (other && m_hold >= int'(MH)) nxt = 1 - m_owner;
        end
        if (nxt >= 0 && nxt != m_owner) begin
            m_hold = 1;
            m_last = nxt;
            m_sel  = (nxt == 1);
        end else if (nxt >= 0) begin
            m_hold++;
        end
        m_owner = nxt;
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] exp_bus;
        exp_bus = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : '0;
        check({tag, ".gnt0"},   32'(gnt0),    32'(m_owner == 0));
        check({tag, ".gnt1"},   32'(gnt1),    32'(m_owner == 1));
        check({tag, ".enable"}, 32'(enable),  32'(m_owner >= 0));
        check({tag, ".sel"},    32'(sel),     32'(m_sel));
        check({tag, ".bus"},    32'(bus_out), 32'(exp_bus));
        check({tag, ".excl"},   32'(gnt0 & gnt1), 32'd0);
    endtask

    // One clock: drive at negedge, advance model at posedge, sample 1 ns later
    task automatic step(input string tag, input logic r0, input logic r1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        req0  = r0;
        req1  = r1;
        data0 = d0;
        data1 = d1;
        @(posedge clk);
        m_step(r0, r1);
        #1;
        check_all(tag);
    endtask

    task automatic sync_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check_all(tag);
        rst_n = 1'b1;
    endtask

    // Reset asserted between edges; outputs must fall without a clock
    task automatic async_reset_mid(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;
        m_reset();
        #3;
        check_all("por");
        sync_reset("rst");

        // Sole requester 0 holds indefinitely
        for (int i = 0; i < 21; i++) step("solo0", 1'b1, 1'b0, DW'(12'h123 + i), DW'(12'hFFF));

        // Contention from reset: 4/4 alternation, first tie to requester 0
        sync_reset("rst2");
        for (int i = 0; i < 16; i++) step("tie", 1'b1, 1'b1, 12'hA5A, 12'h5A5);

        // Owner 0 drops at cnt=1 with req1 pending: direct handover
        sync_reset("rst3");
        step("ho.a", 1'b1, 1'b0, 12'h111, 12'h222);
        step("ho.b", 1'b1, 1'b1, 12'h111, 12'h222);
        step("ho.c", 1'b0, 1'b1, 12'h111, 12'h222);
        step("ho.d", 1'b0, 1'b1, 12'h111, 12'h222);

        // Both drop in OWN1: IDLE with sel held at 1, then tie goes to 0
        step("idle.a", 1'b0, 1'b0, 12'h333, 12'h444);
        check("idle.sel_held", 32'(sel), 32'd1);
        step("idle.b", 1'b0, 1'b0, 12'h333, 12'h444);
        step("idle.tie", 1'b1, 1'b1, 12'h333, 12'h444);
        check("idle.tie_gnt0", 32'(gnt0), 32'd1);

        // Mid-cycle reset during OWN1
        sync_reset("rst4");
        step("ar.a", 1'b0, 1'b1, 12'h0F0, 12'hABC);
        step("ar.b", 1'b0, 1'b1, 12'h0F0, 12'hABC);
        async_reset_mid("ar.rst");
        check("ar.bus_zero", 32'(bus_out), 32'd0);

        // req1 alone saturates, then req0 arrives: switch on next edge
        for (int i = 0; i < 10; i++) step("sat1", 1'b0, 1'b1, 12'h777, 12'h888);
        step("sat.sw", 1'b1, 1'b1, 12'h777, 12'h888);
        check("sat.sw_gnt0", 32'(gnt0), 32'd1);

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), a, b);
            if ($urandom_range(0, 79) == 0) async_reset_mid("rnd.rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
